// File: rtl/uvme_mapu_b_mat_engine.sv
// Matrix APU Block compute stage: loads two NxN unsigned operands row by row,
// computes A*B or A+B one element per cycle, then drains result rows with an overflow flag.
module uvme_mapu_b_mat_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_vld,
  output logic                    o_rdy,
  input  logic                    i_op,
  input  logic [N*DATA_WIDTH-1:0] i_row,
  output logic                    o_vld,
  input  logic                    i_rdy,
  output logic [N*DATA_WIDTH-1:0] o_row,
  output logic                    o_ovf
);

  localparam int FULL_W = 2*DATA_WIDTH + $clog2(N);
  localparam int CW     = $clog2(N*N+1);
  localparam int RW     = $clog2(N);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, COMPUTE, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [RW-1:0]         r_cnt_q, r_cnt_d;
  logic [CW-1:0]         e_cnt_q, e_cnt_d;
  logic [RW-1:0]         ci_q, ci_d;
  logic [RW-1:0]         cj_q, cj_d;
  logic [RW-1:0]         d_cnt_q, d_cnt_d;
  logic                  op_q, op_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] a_q [N][N];
  logic [DATA_WIDTH-1:0] a_d [N][N];
  logic [DATA_WIDTH-1:0] b_q [N][N];
  logic [DATA_WIDTH-1:0] b_d [N][N];
  logic [DATA_WIDTH-1:0] c_q [N][N];
  logic [DATA_WIDTH-1:0] c_d [N][N];
  logic [FULL_W-1:0]     res_p0_q, res_p0_d;
  logic [RW-1:0]         wi_p0_q, wi_p0_d;
  logic [RW-1:0]         wj_p0_q, wj_p0_d;
  logic                  vld_p0_q, vld_p0_d;
  logic [FULL_W-1:0]     elem_full;
  logic                  in_hs;
  logic                  out_hs;

  function automatic logic [DATA_WIDTH-1:0] trunc_elem(input logic [FULL_W-1:0] v);
    return v[DATA_WIDTH-1:0];
  endfunction

  function automatic logic elem_ovf(input logic [FULL_W-1:0] v);
    return |v[FULL_W-1:DATA_WIDTH];
  endfunction

  assign o_rdy  = !reset && (state_q == LOAD_A || state_q == LOAD_B);
  assign o_vld  = !reset && (state_q == DRAIN);
  assign o_ovf  = o_vld && ovf_q;
  assign in_hs  = i_vld && o_rdy;
  assign out_hs = o_vld && i_rdy;

  always_comb begin
    o_row = '0;
    if (o_vld) begin
      for (int j = 0; j < N; j++) begin
        o_row[j*DATA_WIDTH +: DATA_WIDTH] = c_q[d_cnt_q][j];
      end
    end
  end

  // Full-precision element at (ci, cj); truncation happens at writeback
  always_comb begin
    elem_full = '0;
    if (op_q) begin
      for (int k = 0; k < N; k++) begin
        elem_full = elem_full + FULL_W'(a_q[ci_q][k]) * FULL_W'(b_q[k][cj_q]);
      end
    end else begin
      elem_full = FULL_W'(a_q[ci_q][cj_q]) + FULL_W'(b_q[ci_q][cj_q]);
    end
  end

  always_comb begin
    state_d  = state_q;
    r_cnt_d  = r_cnt_q;
    e_cnt_d  = e_cnt_q;
    ci_d     = ci_q;
    cj_d     = cj_q;
    d_cnt_d  = d_cnt_q;
    op_d     = op_q;
    ovf_d    = ovf_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    res_p0_d = res_p0_q;
    wi_p0_d  = wi_p0_q;
    wj_p0_d  = wj_p0_q;
    vld_p0_d = 1'b0;

    case (state_q)
      LOAD_A: begin
        if (in_hs) begin
          for (int j = 0; j < N; j++) begin
            a_d[r_cnt_q][j] = i_row[j*DATA_WIDTH +: DATA_WIDTH];
          end
          if (r_cnt_q == '0) op_d = i_op;
          if (r_cnt_q == RW'(N-1)) begin
            r_cnt_d = '0;
            state_d = LOAD_B;
          end else begin
            r_cnt_d = r_cnt_q + RW'(1);
          end
        end
      end
      LOAD_B: begin
        if (in_hs) begin
          for (int j = 0; j < N; j++) begin
            b_d[r_cnt_q][j] = i_row[j*DATA_WIDTH +: DATA_WIDTH];
          end
          if (r_cnt_q == RW'(N-1)) begin
            r_cnt_d = '0;
            e_cnt_d = '0;
            ci_d    = '0;
            cj_d    = '0;
            state_d = COMPUTE;
          end else begin
            r_cnt_d = r_cnt_q + RW'(1);
          end
        end
      end
      COMPUTE: begin
        // One extra cycle after the last issue lets the final element land in c
        if (e_cnt_q < CW'(N*N)) begin
          vld_p0_d = 1'b1;
          res_p0_d = elem_full;
          wi_p0_d  = ci_q;
          wj_p0_d  = cj_q;
          e_cnt_d  = e_cnt_q + CW'(1);
          if (cj_q == RW'(N-1)) begin
            cj_d = '0;
            ci_d = (ci_q == RW'(N-1)) ? '0 : ci_q + RW'(1);
          end else begin
            cj_d = cj_q + RW'(1);
          end
        end else begin
          d_cnt_d = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_hs) begin
          if (d_cnt_q == RW'(N-1)) begin
            d_cnt_d = '0;
            ovf_d   = 1'b0;
            state_d = LOAD_A;
          end else begin
            d_cnt_d = d_cnt_q + RW'(1);
          end
        end
      end
      default: state_d = LOAD_A;
    endcase

    if (vld_p0_q) begin
      c_d[wi_p0_q][wj_p0_q] = trunc_elem(res_p0_q);
      ovf_d                 = ovf_q | elem_ovf(res_p0_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= LOAD_A;
      r_cnt_q  <= '0;
      e_cnt_q  <= '0;
      ci_q     <= '0;
      cj_q     <= '0;
      d_cnt_q  <= '0;
      op_q     <= 1'b0;
      ovf_q    <= 1'b0;
      res_p0_q <= '0;
      wi_p0_q  <= '0;
      wj_p0_q  <= '0;
      vld_p0_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_q[i][j] <= '0;
          b_q[i][j] <= '0;
          c_q[i][j] <= '0;
        end
      end
    end else begin
      state_q  <= state_d;
      r_cnt_q  <= r_cnt_d;
      e_cnt_q  <= e_cnt_d;
      ci_q     <= ci_d;
      cj_q     <= cj_d;
      d_cnt_q  <= d_cnt_d;
      op_q     <= op_d;
      ovf_q    <= ovf_d;
      res_p0_q <= res_p0_d;
      wi_p0_q  <= wi_p0_d;
      wj_p0_q  <= wj_p0_d;
      vld_p0_q <= vld_p0_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
    end
  end

endmodule

// File: tb/tb_uvme_mapu_b_mat_engine.sv
// Bench for uvme_mapu_b_mat_engine: directed vector table, hand sequences for
// backpressure and mid-operation reset, and random matrices against a reference model.
module tb_uvme_mapu_b_mat_engine;

  localparam int N  = 3;
  localparam int DW = 32;

  typedef logic [N*N-1:0][DW-1:0] mat_t;

  typedef struct {
    string name;
    mat_t  a;
    mat_t  b;
    logic  op;
    logic  toggle;
    mat_t  exp_c;
    logic  exp_ovf;
  } vec_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            i_vld;
  logic            o_rdy;
  logic            i_op;
  logic [N*DW-1:0] i_row;
  logic            o_vld;
  logic            i_rdy;
  logic [N*DW-1:0] o_row;
  logic            o_ovf;

  int tests = 0;
  int fails = 0;

  uvme_mapu_b_mat_engine #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk(clk), .reset(reset), .i_vld(i_vld), .o_rdy(o_rdy), .i_op(i_op),
    .i_row(i_row), .o_vld(o_vld), .i_rdy(i_rdy), .o_row(o_row), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic mat_t fill(input logic [DW-1:0] v);
    mat_t m;
    for (int i = 0; i < N*N; i++) m[i] = v;
    return m;
  endfunction

  // Reference: plain textbook matrix arithmetic in wide integers
  task automatic model(input mat_t a, input mat_t b, input logic op, output mat_t c, output logic ovf);
    logic [2*DW+7:0] acc;
    ovf = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc = '0;
        if (op) begin
          for (int k = 0; k < N; k++) acc += (2*DW+8)'(a[i*N+k]) * (2*DW+8)'(b[k*N+j]);
        end else begin
          acc = (2*DW+8)'(a[i*N+j]) + (2*DW+8)'(b[i*N+j]);
        end
        c[i*N+j] = acc[DW-1:0];
        if (acc[2*DW+7:DW] != 0) ovf = 1'b1;
      end
    end
  endtask

  task automatic send_row(input logic [N*DW-1:0] row, input logic op);
    int n;
    i_vld = 1'b1;
    i_row = row;
    i_op  = op;
    n = 0;
    while (!o_rdy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: o_rdy never rose");
    end
    @(posedge clk); #1;
  endtask

  task automatic send_mats(input mat_t a, input mat_t b, input logic op, input logic toggle,
                           input int b_rows);
    logic [N*DW-1:0] row;
    for (int r = 0; r < N; r++) begin
      row = a[r*N +: N];
      send_row(row, (r == 0) ? op : (toggle ? ~op : op));
    end
    for (int r = 0; r < b_rows; r++) begin
      row = b[r*N +: N];
      send_row(row, toggle ? ~op : op);
    end
    i_vld = 1'b0;
  endtask

  task automatic run_vec(input string name, input mat_t a, input mat_t b, input logic op,
                         input logic toggle, input mat_t ec, input logic eovf, input logic rand_rdy);
    int lat;
    int n;
    logic [N*DW-1:0] row;
    i_rdy = 1'b1;
    send_mats(a, b, op, toggle, N);
    lat = 0;
    while (!o_vld && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, (N*DW)'(lat), (N*DW)'(N*N+1));
    for (int r = 0; r < N; r++) begin
      n = 0;
      i_rdy = rand_rdy ? 1'($urandom % 2) : 1'b1;
      while (!(o_vld && i_rdy) && n < 100) begin
        @(posedge clk); #1;
        i_rdy = rand_rdy ? 1'($urandom % 2) : 1'b1;
        n++;
      end
      row = ec[r*N +: N];
      check($sformatf("%s_row%0d", name, r), o_row, row);
      check($sformatf("%s_ovf%0d", name, r), (N*DW)'(o_ovf), (N*DW)'(eovf));
      @(posedge clk); #1;
    end
    i_rdy = 1'b1;
    check({name, "_rdy_after"}, (N*DW)'({o_rdy, o_vld}), (N*DW)'(2'b10));
  endtask

  vec_t tbl[4];
  mat_t ra, rb, rc, m;
  logic rovf, rop, ov0, stable;
  logic [N*DW-1:0] r0, row;
  int n;

  initial begin
    reset = 1'b1; i_vld = 1'b0; i_op = 1'b0; i_row = '0; i_rdy = 1'b1;

    tbl[0].name = "ident_mult";
    tbl[0].a = fill(0); tbl[0].a[0] = 1; tbl[0].a[4] = 1; tbl[0].a[8] = 1;
    for (int k = 0; k < N*N; k++) tbl[0].b[k] = DW'(k+1);
    tbl[0].op = 1'b1; tbl[0].toggle = 1'b0;
    for (int k = 0; k < N*N; k++) tbl[0].exp_c[k] = DW'(k+1);
    tbl[0].exp_ovf = 1'b0;

    tbl[1].name = "add_5_7";
    tbl[1].a = fill(5); tbl[1].b = fill(7); tbl[1].op = 1'b0; tbl[1].toggle = 1'b0;
    tbl[1].exp_c = fill(12); tbl[1].exp_ovf = 1'b0;

    tbl[2].name = "mult_ovf";
    tbl[2].a = fill(0); tbl[2].a[0] = 32'hFFFF_FFFF;
    tbl[2].b = fill(0); tbl[2].b[0] = 2;
    tbl[2].op = 1'b1; tbl[2].toggle = 1'b0;
    tbl[2].exp_c = fill(0); tbl[2].exp_c[0] = 32'hFFFF_FFFE; tbl[2].exp_ovf = 1'b1;

    tbl[3].name = "op_toggle";
    tbl[3].a = fill(1); tbl[3].b = fill(1); tbl[3].op = 1'b1; tbl[3].toggle = 1'b1;
    tbl[3].exp_c = fill(3); tbl[3].exp_ovf = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_rdy", (N*DW)'(o_rdy), '0);
    check("reset_vld", (N*DW)'(o_vld), '0);
    check("reset_row", o_row, '0);
    check("reset_ovf", (N*DW)'(o_ovf), '0);
    reset = 1'b0;
    #1;
    check("post_reset_rdy", (N*DW)'(o_rdy), (N*DW)'(1));

    for (int t = 0; t < 4; t++) begin
      run_vec(tbl[t].name, tbl[t].a, tbl[t].b, tbl[t].op, tbl[t].toggle,
              tbl[t].exp_c, tbl[t].exp_ovf, 1'b0);
    end

    // Backpressure: hold i_rdy low for 20 cycles in DRAIN
    i_rdy = 1'b0;
    send_mats(fill(3), fill(4), 1'b0, 1'b0, N);
    n = 0;
    while (!o_vld && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    r0 = o_row; ov0 = o_ovf; stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (o_row !== r0 || o_vld !== 1'b1 || o_ovf !== ov0 || o_rdy !== 1'b0) stable = 1'b0;
    end
    check("bp_stable", (N*DW)'(stable), (N*DW)'(1));
    m = fill(7);
    row = m[0 +: N];
    check("bp_row0_held", r0, row);
    i_rdy = 1'b1;
    check("bp_row0", o_row, row);
    @(posedge clk); #1;
    check("bp_row1", o_row, row);
    check("bp_vld1", (N*DW)'(o_vld), (N*DW)'(1));
    @(posedge clk); #1;
    check("bp_row2", o_row, row);
    check("bp_vld2", (N*DW)'(o_vld), (N*DW)'(1));
    @(posedge clk); #1;
    check("bp_rdy_next", (N*DW)'({o_rdy, o_vld}), (N*DW)'(2'b10));

    // Reset after the second B row, then a clean add
    send_mats(fill(9), fill(9), 1'b1, 1'b0, 2);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_reset_rdy", (N*DW)'(o_rdy), '0);
    check("mid_reset_vld", (N*DW)'(o_vld), '0);
    check("mid_reset_row", o_row, '0);
    check("mid_reset_ovf", (N*DW)'(o_ovf), '0);
    reset = 1'b0;
    #1;
    check("mid_reset_rdy_after", (N*DW)'(o_rdy), (N*DW)'(1));
    run_vec("fresh_add", fill(1), fill(1), 1'b0, 1'b0, fill(2), 1'b0, 1'b0);

    // Random matrices, random output backpressure
    for (int t = 0; t < 10; t++) begin
      rop = 1'($urandom % 2);
      for (int k = 0; k < N*N; k++) begin
        ra[k] = ($urandom % 4 == 0) ? DW'($urandom) : DW'($urandom_range(0, 15));
        rb[k] = ($urandom % 4 == 0) ? DW'($urandom) : DW'($urandom_range(0, 15));
      end
      model(ra, rb, rop, rc, rovf);
      run_vec($sformatf("rand%0d", t), ra, rb, rop, 1'b0, rc, rovf, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
